// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart transmitter between NReq byte
// requesters and sequences the send/txbusy handshake with an idle gap.
module uart_tx_arb #(
  parameter int NReq         = 4,
  parameter int Gap          = 2,
  parameter int StartTimeout = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NReq-1:0]   req,
  input  logic [8*NReq-1:0] data,
  output logic [NReq-1:0]   ack,
  output logic              err,
  output logic [2:0]        grant,
  output logic              active,
  output logic [7:0]        tx_din,
  output logic              tx_send,
  input  logic              tx_busy
);

  localparam int CntW = 16;

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      grant_d, pick;
  logic [7:0]      din_d, pick_din;
  logic            send_d, err_d, found;
  logic [NReq-1:0] ack_d;

  assign active = (state_q != IDLE);

  // Scan ptr+NReq down to ptr+1 so the requester closest after ptr wins.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    pick_din = '0;
    for (int i = NReq; i >= 1; i--) begin
      if (req[(int'(ptr_q) + i) % NReq]) begin
        found = 1'b1;
        pick  = 3'((int'(ptr_q) + i) % NReq);
      end
    end
    for (int j = 0; j < NReq; j++) begin
      if (pick == 3'(j)) pick_din = data[8*j +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    din_d   = tx_din;
    send_d  = tx_send;
    err_d   = 1'b0;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          grant_d = pick;
          din_d   = pick_din;
          send_d  = 1'b1;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // A uart response on the timeout edge still counts as accepted.
        if (tx_busy) begin
          send_d = 1'b0;
          for (int j = 0; j < NReq; j++) begin
            if (grant == 3'(j)) ack_d[j] = 1'b1;
          end
          ptr_d   = grant;
          state_d = BUSY;
        end else if (cnt_q == CntW'(StartTimeout - 1)) begin
          send_d  = 1'b0;
          err_d   = 1'b1;
          ptr_d   = grant;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (!tx_busy) begin
          if (Gap == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = CntW'(Gap - 1);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'(NReq - 1);
      cnt_q   <= '0;
      grant   <= '0;
      tx_din  <= '0;
      tx_send <= 1'b0;
      ack     <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant   <= grant_d;
      tx_din  <= din_d;
      tx_send <= send_d;
      ack     <= ack_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: behavioural uart and requesters driven on the falling
// edge, with a round-robin scoreboard checking grants, bytes, gaps and pulses.
module tb_uart_tx_arb;

  localparam int NReq         = 4;
  localparam int Gap          = 5;
  localparam int StartTimeout = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic [NReq-1:0]   req;
  logic [8*NReq-1:0] data;
  logic [NReq-1:0]   ack;
  logic              err;
  logic [2:0]        grant;
  logic              active;
  logic [7:0]        tx_din;
  logic              tx_send;
  logic              tx_busy;

  always #5 clk = ~clk;

  uart_tx_arb #(.NReq(NReq), .Gap(Gap), .StartTimeout(StartTimeout)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .ack(ack), .err(err),
    .grant(grant), .active(active), .tx_din(tx_din), .tx_send(tx_send),
    .tx_busy(tx_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // uart model
  logic       busy_m = 1'b0;
  int         busy_cnt = 0;
  bit         uart_en = 1'b1;
  bit         rand_len = 1'b0;
  int         frame_len = 3;
  logic [7:0] last_rx = '0;
  logic [7:0] rx_q[$];

  // scoreboard
  int         ptr_m = NReq - 1;
  int         cur_g = -1;
  logic [7:0] exp_byte = '0;
  bit         inflight[NReq];
  int         g_q[$];
  int         cyc = 0, fall_cyc = -1, last_gap = -1;
  bit         ignore_fall = 1'b0;
  int         send_run = 0, last_run = 0;
  int         n_ack[NReq];
  int         n_err = 0, n_grant = 0;
  logic       send_prev = 1'b0;

  // random requester policy
  bit auto_on = 1'b0;
  int keep_pct = 0, raise_pct = 0, mut_pct = 0, drop_pct = 0;

  function automatic int rr_pick(input logic [NReq-1:0] r, input int p);
    for (int k = 1; k <= NReq; k++) begin
      if (r[(p + k) % NReq]) return (p + k) % NReq;
    end
    return -1;
  endfunction

  task automatic tick();
    int g;
    @(negedge clk);
    cyc++;
    check("ack_onehot", 32'($countones(ack) <= 1), 1);
    check("ack_err_excl", 32'((|ack) && err), 0);
    check("grant_range", 32'(grant < NReq), 1);
    check("send_active", 32'(tx_send && !active), 0);
    if (tx_send && !send_prev) begin
      g = rr_pick(req, ptr_m);
      n_grant++;
      check("grant_has_req", 32'(g >= 0), 1);
      if (g >= 0) begin
        check("grant", 32'(grant), 32'(g));
        check("grant_din", 32'(tx_din), 32'(data[8*g +: 8]));
        inflight[g] = 1'b1;
      end
      check("grant_busy", 32'(tx_busy), 0);
      if (fall_cyc >= 0) begin
        last_gap = cyc - fall_cyc - 1;
        check("gap_min", 32'(last_gap >= Gap + 1), 1);
        fall_cyc = -1;
      end
      cur_g    = g;
      exp_byte = tx_din;
      g_q.push_back(g);
    end
    if (|ack) begin
      check("ack_expected", 32'(cur_g >= 0), 1);
      if (cur_g >= 0) begin
        check("ack_who", 32'(ack), 32'(1) << cur_g);
        check("ack_byte", 32'(last_rx), 32'(exp_byte));
        n_ack[cur_g]++;
        inflight[cur_g] = 1'b0;
        ptr_m = cur_g;
        cur_g = -1;
      end
    end
    if (err) begin
      check("err_expected", 32'(!uart_en && cur_g >= 0), 1);
      n_err++;
      if (cur_g >= 0) begin
        inflight[cur_g] = 1'b0;
        ptr_m = cur_g;
      end
      cur_g = -1;
    end
    if (tx_send) send_run++;
    else if (send_prev) begin
      last_run = send_run;
      send_run = 0;
    end
    send_prev = tx_send;
    // uart: latch din on send, stay busy frame_len cycles
    if (busy_m) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        busy_m = 1'b0;
        if (ignore_fall) ignore_fall = 1'b0;
        else             fall_cyc = cyc;
      end
    end else if (tx_send && uart_en && reset) begin
      if (rand_len) frame_len = $urandom_range(2, 6);
      busy_m   = 1'b1;
      busy_cnt = frame_len;
      last_rx  = tx_din;
      rx_q.push_back(tx_din);
    end
    tx_busy = busy_m;
    if (auto_on) begin
      for (int i = 0; i < NReq; i++) begin
        if (ack[i]) begin
          if (req[i] && $urandom_range(0, 99) < keep_pct) data[8*i +: 8] = data[8*i +: 8] + 8'd1;
          else req[i] = 1'b0;
        end else if (inflight[i]) begin
          if (tx_send && $urandom_range(0, 99) < mut_pct) data[8*i +: 8] = 8'($urandom);
          if (tx_send && $urandom_range(0, 99) < drop_pct) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 99) < raise_pct) begin
          req[i] = 1'b1;
          data[8*i +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    tick();
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_send", 32'(tx_send), 0);
    check("rst_din", 32'(tx_din), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_active", 32'(active), 0);
    ptr_m = NReq - 1;
    cur_g = -1;
    for (int i = 0; i < NReq; i++) inflight[i] = 1'b0;
    fall_cyc    = -1;
    ignore_fall = busy_m;
    reset = 1'b1;
  endtask

  task automatic wait_quiet(input int lim);
    bit ok = 1'b0;
    for (int n = 0; n < lim && !ok; n++) begin
      if (!active && !tx_busy && req == '0 && cur_g < 0) ok = 1'b1;
      else tick();
    end
    check("quiet_reached", 32'(ok), 1);
  endtask

  initial begin
    int n, a0, e0, g0;
    reset   = 1'b0;
    req     = '0;
    data    = '0;
    tx_busy = 1'b0;
    for (int i = 0; i < NReq; i++) begin
      inflight[i] = 1'b0;
      n_ack[i]    = 0;
    end
    tick();
    do_reset();
    tick();
    tick();
    check("idle_ack", 32'(ack), 0);
    check("idle_err", 32'(err), 0);
    check("idle_send", 32'(tx_send), 0);
    check("idle_active", 32'(active), 0);

    // single byte from requester 0
    auto_on = 1'b1;
    keep_pct = 0;
    data[7:0] = 8'hA9;
    req = 4'b0001;
    tick();
    check("t1_send_next", 32'(tx_send), 1);
    wait_quiet(100);
    check("t1_acks", 32'(n_ack[0]), 1);
    check("t1_rx", 32'(rx_q[$]), 32'h00A9);

    // fairness, all requesters held, byte incremented after each ack
    do_reset();
    rx_q.delete();
    g_q.delete();
    keep_pct = 100;
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req  = '1;
    n = 0;
    while (rx_q.size() < 8 && n < 600) begin tick(); n++; end
    check("t2_frames", 32'(rx_q.size() >= 8), 1);
    keep_pct = 0;
    wait_quiet(300);
    for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
      check("t2_rr_byte", 32'(rx_q[k]), 32'(8'(8'h11 * (k % 4 + 1) + k / 4)));
      check("t2_rr_grant", 32'(g_q[k]), 32'(k % 4));
    end

    // back-to-back frames from one requester
    frame_len = 4;
    keep_pct  = 100;
    g0 = n_grant;
    data[7:0] = 8'h30;
    req = 4'b0001;
    n = 0;
    while (n_grant < g0 + 3 && n < 300) begin tick(); n++; end
    check("t3_gap_exact", 32'(last_gap), 32'(Gap + 1));
    keep_pct = 0;
    wait_quiet(200);

    // start timeout with the uart disconnected
    auto_on = 1'b0;
    uart_en = 1'b0;
    a0 = n_ack[2];
    e0 = n_err;
    data[23:16] = 8'h3C;
    req = 4'b0100;
    n = 0;
    while (!err && n < 100) begin tick(); n++; end
    req = '0;
    check("t4_err", 32'(n_err - e0), 1);
    check("t4_send_len", 32'(last_run), 32'(StartTimeout));
    check("t4_no_ack", 32'(n_ack[2] - a0), 0);
    tick();
    check("t4_err_pulse", 32'(err), 0);
    data[7:0] = 8'h01;
    req = 4'b0001;
    n = 0;
    while (!err && n < 100) begin tick(); n++; end
    req = '0;
    check("t4_regrant", 32'(g_q[$]), 0);
    check("t4_err2", 32'(n_err - e0), 2);
    uart_en = 1'b1;
    wait_quiet(50);

    // reset while the uart frame is in flight
    auto_on   = 1'b1;
    frame_len = 30;
    data[31:24] = 8'h66;
    req = 4'b1000;
    n = 0;
    while (!ack[3] && n < 100) begin tick(); n++; end
    check("t5_ack", 32'(ack[3]), 1);
    tick();
    tick();
    reset = 1'b0;
    req   = '0;
    tick();
    check("t5_rst_send", 32'(tx_send), 0);
    check("t5_rst_active", 32'(active), 0);
    check("t5_rst_ack", 32'(ack), 0);
    check("t5_uart_busy", 32'(tx_busy), 1);
    do_reset();
    a0 = n_ack[1];
    data[15:8] = 8'h5A;
    req = 4'b0010;
    wait_quiet(200);
    check("t5_ack1", 32'(n_ack[1] - a0), 1);
    check("t5_rx", 32'(rx_q[$]), 32'h005A);

    // requester 2 withdraws after grant; data changes too
    auto_on   = 1'b0;
    frame_len = 3;
    a0 = n_ack[2];
    g0 = n_grant;
    data[23:16] = 8'h7E;
    req = 4'b0100;
    n = 0;
    while (!tx_send && n < 50) begin tick(); n++; end
    tick();
    req[2] = 1'b0;
    data[23:16] = 8'hFF;
    for (int k = 0; k < 40; k++) tick();
    check("t6_ack_once", 32'(n_ack[2] - a0), 1);
    check("t6_one_grant", 32'(n_grant - g0), 1);
    check("t6_rx", 32'(rx_q[$]), 32'h007E);

    // randomized traffic
    auto_on   = 1'b1;
    rand_len  = 1'b1;
    keep_pct  = 60;
    raise_pct = 20;
    mut_pct   = 10;
    drop_pct  = 5;
    g0 = n_grant;
    a0 = 0;
    for (int i = 0; i < NReq; i++) a0 += n_ack[i];
    for (int k = 0; k < 3000; k++) tick();
    keep_pct  = 0;
    raise_pct = 0;
    mut_pct   = 0;
    drop_pct  = 0;
    wait_quiet(2000);
    e0 = 0;
    for (int i = 0; i < NReq; i++) e0 += n_ack[i];
    check("t7_acks_eq_grants", 32'(e0 - a0), 32'(n_grant - g0));
    check("t7_traffic", 32'(n_grant - g0 > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
